fpu_stream_ctrl: RTL

Sequential issue/collect stage around the combinational `fpu_top`. It accepts FPU commands over a valid/ready handshake and registers them onto the `fpu_top` operand inputs. After a fixed settle time it samples the result and flags into a small show-ahead result FIFO, which drains over a second valid/ready handshake. It also keeps sticky exception flags for software/bench status.

---
 rtl/fpu_stream_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_stream_ctrl.sv
// Issue/collect stage around combinational fpu_top with show-ahead result FIFO.
// Optional stats counters: define FPU_STREAM_STATS_EN.
module fpu_stream_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic        fpu_error,
  input  logic        fpu_underflow,
  input  logic        fpu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_op,
  output logic [2:0]  out_flags,
  output logic        busy,
  input  logic        clr_sticky,
  output logic [2:0]  sticky_flags,
  output logic [15:0] op_count,
  output logic [15:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT_SPACE
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       rdy_en;
  logic       accept, wr, pop, wr_ok;
  logic       full, empty;
  logic [2:0] wflags;

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [36:0]   mem [FIFO_DEPTH];
  logic [36:0]   head;

  assign wflags = {fpu_error, fpu_underflow, fpu_overflow};
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign pop    = !empty && out_ready;
  assign wr_ok  = !full || pop;

  // rdy_en keeps in_ready low during reset and until the first edge after it
  assign in_ready = rdy_en && (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SETTLE;
          cnt_nx   = 4'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (wr_ok) begin
            wr       = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (wr_ok) begin
          wr       = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdy_en <= 1'b0;
      fpu_op <= '0;
      fpu_a  <= '0;
      fpu_b  <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rdy_en <= 1'b1;
      if (accept) begin
        fpu_op <= in_op;
        fpu_a  <= in_a;
        fpu_b  <= in_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {fpu_op, fpu_result, wflags};
  end

  // Outputs forced to zero while empty so stale storage never leaks out
  assign head       = mem[rptr];
  assign out_valid  = !empty;
  assign out_op     = out_valid ? head[36:35] : '0;
  assign out_result = out_valid ? head[34:3] : '0;
  assign out_flags  = out_valid ? head[2:0] : '0;
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (clr_sticky) begin
      sticky_flags <= wr ? wflags : 3'b000;
    end else if (wr) begin
      sticky_flags <= sticky_flags | wflags;
    end
  end

`ifdef FPU_STREAM_STATS_EN
  logic [15:0] opc, errc;
  logic        err_wr;

  assign err_wr = wr && (|wflags);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc  <= '0;
      errc <= '0;
    end else if (clr_sticky) begin
      opc  <= wr ? 16'd1 : 16'd0;
      errc <= err_wr ? 16'd1 : 16'd0;
    end else begin
      if (wr && opc != 16'hFFFF) opc <= opc + 16'd1;
      if (err_wr && errc != 16'hFFFF) errc <= errc + 16'd1;
    end
  end

  assign op_count  = opc;
  assign err_count = errc;
`else
  assign op_count  = '0;
  assign err_count = '0;
`endif

endmodule
